tcdm_read_streamer: RTL and testbench
=====================================

# tcdm_read_streamer

Strided read streamer that sits directly upstream of `tcdm_subsys` on one of its request ports. Once configured, it generates a sequence of TCDM read requests. It collects the in-order read responses into a credit-protected FIFO and presents them as a valid/ready data stream to an accelerator datapath. The `tcdm_req_*` side of the block is pin-compatible with one lane of the `tcdm_subsys` request/response vectors.

## Interface
Parameters:
- `NarrowDataWidth`, 64: TCDM word width in bits.
- `TCDMAddrWidth`, 12: byte address width (8 banks x 64 deep x 8 B).
- `FifoDepth`, 4: response FIFO entries; must be ≥ 2.
- `CountWidth`, 16: width of the word count.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `base_addr_i` in TCDMAddrWidth: byte address of the first word.
- `stride_i` in TCDMAddrWidth: byte increment between requests.
- `num_words_i` in CountWidth: number of words to read.
- `busy_o` out 1: high in RUN or DRAIN.
- `done_o` out 1: one-cycle completion pulse.
- `tcdm_req_addr_o` out TCDMAddrWidth: request address.
- `tcdm_req_write_o` out 1: constant 0.
- `tcdm_req_amo_o` out 4: constant 0.
- `tcdm_req_strb_o` out NarrowDataWidth/8: constant all ones.
- `tcdm_req_q_valid_o` out 1: request valid.
- `tcdm_rsp_q_ready_i` in 1: request accepted by the subsystem.
- `tcdm_rsp_p_valid_i` in 1: response valid, one cycle per word.
- `tcdm_rsp_data_i` in NarrowDataWidth: response data.
- `data_o` out NarrowDataWidth: stream data (FIFO head).
- `data_valid_o` out 1: stream valid.
- `data_ready_i` in 1: stream ready.
- `stall_cnt_o` out 32: present only with the configuration macro; see Configuration.

## Operation
State machine with three states: IDLE, RUN, DRAIN.

- **IDLE**
  - `start_i` with `num_words_i` > 0: latch base, stride and count; clear the issue, outstanding and receive counters; go to RUN.
  - `start_i` with `num_words_i` = 0: pulse `done_o` on the next cycle; stay in IDLE; `busy_o` stays 0.
- **RUN**
  - Drive `tcdm_req_q_valid_o` while issued < count and credits are available.
  - Credits are available when outstanding + FIFO occupancy < FifoDepth.
  - A request is transferred when valid && `tcdm_rsp_q_ready_i`; this increments issued and outstanding.
  - Address of request k = base + k*stride, truncated modulo 2^TCDMAddrWidth (silent wrap-around).
  - Once asserted, valid and addr hold stable until the request is accepted. Valid is never withdrawn.
  - The cycle the last request is accepted, go to DRAIN.
- **DRAIN**
  - Wait until all responses are received and the last stream word has been popped.
  - Then pulse `done_o`, drop `busy_o`, and return to IDLE.
- **Responses** (in any state)
  - A `tcdm_rsp_p_valid_i` is pushed into the FIFO and decrements outstanding.
  - Responses arrive in request order.
  - A response arriving while outstanding = 0 is dropped (this covers stale responses after reset).
  - Credits guarantee the FIFO never overflows.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- `start_i` is ignored while `busy_o` = 1.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `tcdm_req_q_valid_o`=0, `tcdm_req_addr_o`=0, `data_valid_o`=0, `data_o`=0, `stall_cnt_o`=0; state IDLE; FIFO empty.
- Reset asserted mid-operation aborts immediately. Nothing is replayed.
- `start_i` at cycle t: first `tcdm_req_q_valid_o` at t+1.
- With memory latency L, `data_valid_o` rises one cycle after the matching `tcdm_rsp_p_valid_i`.
  - For L=1: request at t+1, response at t+2, data at t+3.
- Throughput is one request per cycle when FifoDepth ≥ L+2 and the consumer is always ready.
- `done_o` is asserted the cycle after the final `data_valid_o && data_ready_i` handshake.

## Configuration
- Macro: `TCDM_STREAMER_STALL_CNT_EN`.
- **Defined:**
  - `stall_cnt_o` exists.
  - It counts cycles where `tcdm_req_q_valid_o` && !`tcdm_rsp_q_ready_i`.
  - It is cleared on an accepted start and saturates at 2^32-1.
- **Undefined:** the port and the counter are absent, and the block is otherwise identical.

## Test plan
- **Basic stream:** memory preloaded; base 0, stride 8, n=6, L=1, all readies high → addresses 0,8,…,40 issued on consecutive cycles; `data_o` yields the six words in order; `done_o` pulses once, one cycle after the last pop.
- **Consumer backpressure:** `data_ready_i`=0, n=8, FifoDepth=4 → exactly 4 requests issued, then `tcdm_req_q_valid_o` drops. Releasing ready → the remaining 4 are issued and no data is lost or reordered.
- **Request stall:** `tcdm_rsp_q_ready_i` held low 3 cycles on the second request → addr 8 and valid held stable for 3 cycles; `stall_cnt_o`=3 with the macro defined.
- **Wrap-around:** base 0xFF8, stride 8, n=3 → addresses 0xFF8, 0x000, 0x008.
- **Zero count:** `num_words_i`=0 with `start_i` → no request is issued, `busy_o` stays 0, and `done_o` pulses on the next cycle.
- **Start while busy, then reset:** `start_i` pulsed during RUN is ignored. `rst_ni` asserted mid-RUN → all outputs at reset values; late responses are dropped; a fresh start works normally.

Source files
------------

// File: rtl/tcdm_read_streamer.sv
// Strided TCDM read streamer: issues credit-limited read requests and streams the in-order responses.
// Optional stall counter on stall_cnt_o is enabled by defining TCDM_STREAMER_STALL_CNT_EN.
module tcdm_read_streamer #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned TCDMAddrWidth   = 12,
  parameter int unsigned FifoDepth       = 4,
  parameter int unsigned CountWidth      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [TCDMAddrWidth-1:0]     base_addr_i,
  input  logic [TCDMAddrWidth-1:0]     stride_i,
  input  logic [CountWidth-1:0]        num_words_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
  output logic                         tcdm_req_write_o,
  output logic [3:0]                   tcdm_req_amo_o,
  output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
  output logic                         tcdm_req_q_valid_o,
  input  logic                         tcdm_rsp_q_ready_i,
  input  logic                         tcdm_rsp_p_valid_i,
  input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
  output logic [NarrowDataWidth-1:0]   data_o,
  output logic                         data_valid_o,
  input  logic                         data_ready_i
`ifdef TCDM_STREAMER_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned OccW = $clog2(FifoDepth + 1);
  localparam logic [OccW:0] DepthVal = (OccW + 1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [TCDMAddrWidth-1:0]     addr_q, stride_q;
  logic [CountWidth-1:0]        count_q, issued_q;
  logic [OccW-1:0]              outst_q, outst_d, occ_q, occ_d;
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [NarrowDataWidth-1:0]   fifo_q [FifoDepth];
  logic                         done_q;

  logic start_ok, has_credit, req_valid, req_fire, last_fire;
  logic push, pop, drain_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // In-flight requests plus buffered words may never exceed the FIFO size.
  assign has_credit = ({1'b0, outst_q} + {1'b0, occ_q}) < DepthVal;
  assign start_ok   = (state_q == IDLE) && start_i;
  assign req_valid  = (state_q == RUN) && (issued_q < count_q) && has_credit;
  assign req_fire   = req_valid && tcdm_rsp_q_ready_i;
  assign last_fire  = req_fire && ((issued_q + CountWidth'(1)) == count_q);
  assign push       = tcdm_rsp_p_valid_i && (outst_q != '0);
  assign pop        = (occ_q != '0) && data_ready_i;

  always_comb begin
    outst_d = outst_q;
    occ_d   = occ_q;
    if (req_fire && !push)      outst_d = outst_q + OccW'(1);
    else if (!req_fire && push) outst_d = outst_q - OccW'(1);
    if (push && !pop)           occ_d = occ_q + OccW'(1);
    else if (!push && pop)      occ_d = occ_q - OccW'(1);
  end

  assign drain_done = (state_q == DRAIN) && (outst_d == '0) && (occ_d == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && (num_words_i != '0)) state_d = RUN;
      RUN:     if (last_fire) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      done_q  <= (start_ok && (num_words_i == '0)) || drain_done;
      if (start_ok) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        count_q  <= num_words_i;
        issued_q <= '0;
        outst_q  <= '0;
      end else begin
        outst_q <= outst_d;
        // Address wraps silently modulo the address width.
        if (req_fire) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + CountWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= tcdm_rsp_data_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

`ifdef TCDM_STREAMER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                 stall_q <= '0;
    else if (start_ok)                                           stall_q <= '0;
    else if (req_valid && !tcdm_rsp_q_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign tcdm_req_addr_o    = addr_q;
  assign tcdm_req_write_o   = 1'b0;
  assign tcdm_req_amo_o     = 4'h0;
  assign tcdm_req_strb_o    = '1;
  assign tcdm_req_q_valid_o = req_valid;
  assign data_valid_o       = (occ_q != '0);
  assign data_o             = data_valid_o ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_tcdm_read_streamer.sv
// Scoreboard testbench for tcdm_read_streamer with a one-cycle-latency memory model.
// Stall counter checks are active when TCDM_STREAMER_STALL_CNT_EN is defined.
module tb_tcdm_read_streamer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [11:0] base_addr_i = '0;
  logic [11:0] stride_i = '0;
  logic [15:0] num_words_i = '0;
  logic        busy_o, done_o;
  logic [11:0] tcdm_req_addr_o;
  logic        tcdm_req_write_o;
  logic [3:0]  tcdm_req_amo_o;
  logic [7:0]  tcdm_req_strb_o;
  logic        tcdm_req_q_valid_o;
  logic        tcdm_rsp_q_ready_i = 1'b1;
  logic        tcdm_rsp_p_valid_i = 1'b0;
  logic [63:0] tcdm_rsp_data_i = '0;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i = 1'b1;
`ifdef TCDM_STREAMER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  tcdm_read_streamer dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .base_addr_i        (base_addr_i),
    .stride_i           (stride_i),
    .num_words_i        (num_words_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .tcdm_req_addr_o    (tcdm_req_addr_o),
    .tcdm_req_write_o   (tcdm_req_write_o),
    .tcdm_req_amo_o     (tcdm_req_amo_o),
    .tcdm_req_strb_o    (tcdm_req_strb_o),
    .tcdm_req_q_valid_o (tcdm_req_q_valid_o),
    .tcdm_rsp_q_ready_i (tcdm_rsp_q_ready_i),
    .tcdm_rsp_p_valid_i (tcdm_rsp_p_valid_i),
    .tcdm_rsp_data_i    (tcdm_rsp_data_i),
    .data_o             (data_o),
    .data_valid_o       (data_valid_o),
    .data_ready_i       (data_ready_i)
`ifdef TCDM_STREAMER_STALL_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int req_cnt = 0;
  int stall_obs = 0;
  int first_req_cyc = -1;
  int last_req_cyc = -1;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  int start_cyc = 0;
  logic [11:0] exp_addr [$];
  logic [63:0] exp_data [$];

  function automatic logic [63:0] memWord(input logic [11:0] a);
    return {16'hDA7A, 4'h0, a, 20'hF00D0, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [11:0] a);
    exp_addr.push_back(a);
    exp_data.push_back(memWord(a));
  endtask

  task automatic clearStats();
    req_cnt = 0;
    stall_obs = 0;
    first_req_cyc = -1;
    last_req_cyc = -1;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
  endtask

  // Pulses start for one cycle; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [11:0] base, input logic [11:0] stride, input logic [15:0] n);
    @(posedge clk); #1;
    start_cyc = cyc;
    base_addr_i = base;
    stride_i = stride;
    num_words_i = n;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int maxCyc, input string name);
    int n = 0;
    while (done_cnt == d0 && n < maxCyc) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, " addr queue empty"}, 64'(exp_addr.size()), 64'd0);
    checkOutput({name, " data queue empty"}, 64'(exp_data.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: one-cycle read latency, blind to reset so stale responses appear.
  initial begin
    logic        fire;
    logic [11:0] a;
    forever begin
      @(negedge clk);
      fire = tcdm_req_q_valid_o && tcdm_rsp_q_ready_i;
      a = tcdm_req_addr_o;
      @(posedge clk); #1;
      tcdm_rsp_p_valid_i = fire;
      tcdm_rsp_data_i = fire ? memWord(a) : 64'h0;
    end
  end

  // Scoreboard monitor: compares requests and stream pops against the expected queues.
  initial forever begin
    @(negedge clk);
    if (done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (tcdm_req_q_valid_o) begin
      if (exp_addr.size() == 0) begin
        checkOutput("unexpected request addr", 64'(tcdm_req_addr_o), 64'hFFFF_FFFF);
      end else if (tcdm_rsp_q_ready_i) begin
        checkOutput("request addr", 64'(tcdm_req_addr_o), 64'(exp_addr.pop_front()));
        req_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        last_req_cyc = cyc;
      end else begin
        checkOutput("stalled addr", 64'(tcdm_req_addr_o), 64'(exp_addr[0]));
        stall_obs++;
      end
    end
    if (data_valid_o && data_ready_i) begin
      if (exp_data.size() == 0) checkOutput("unexpected stream word", data_o, 64'hDEAD_DEAD_DEAD_DEAD);
      else checkOutput("stream data", data_o, exp_data.pop_front());
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [11:0] basicAddrs [6] = '{12'h000, 12'h008, 12'h010, 12'h018, 12'h020, 12'h028};
  logic [11:0] wrapAddrs  [3] = '{12'hFF8, 12'h000, 12'h008};

  initial begin
    int d0;

    // Reset values
    #12;
    checkOutput("reset busy", 64'(busy_o), 64'd0);
    checkOutput("reset done", 64'(done_o), 64'd0);
    checkOutput("reset req valid", 64'(tcdm_req_q_valid_o), 64'd0);
    checkOutput("reset req addr", 64'(tcdm_req_addr_o), 64'd0);
    checkOutput("reset data valid", 64'(data_valid_o), 64'd0);
    checkOutput("reset data", data_o, 64'd0);
`ifdef TCDM_STREAMER_STALL_CNT_EN
    checkOutput("reset stall cnt", 64'(stall_cnt), 64'd0);
`endif
    checkOutput("req write const", 64'(tcdm_req_write_o), 64'd0);
    checkOutput("req amo const", 64'(tcdm_req_amo_o), 64'd0);
    checkOutput("req strb const", 64'(tcdm_req_strb_o), 64'hFF);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;

    // Basic stream, all readies high
    $display("[TB] basic stream");
    clearStats();
    foreach (basicAddrs[i]) pushExpect(basicAddrs[i]);
    d0 = done_cnt;
    applyStimulus(12'h000, 12'h008, 16'd6);
    waitDone(d0, 50, "basic done timeout");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("basic first request cycle", 64'(first_req_cyc), 64'(start_cyc + 1));
    checkOutput("basic first data cycle", 64'(first_pop_cyc), 64'(start_cyc + 3));
    checkOutput("basic back-to-back requests", 64'(last_req_cyc - first_req_cyc), 64'd5);
    checkOutput("basic done pulses", 64'(done_cnt - d0), 64'd1);
    checkOutput("basic done after last pop", 64'(last_done_cyc), 64'(last_pop_cyc + 1));
    checkOutput("basic busy after done", 64'(busy_o), 64'd0);
    checkDrained("basic");

    // Consumer backpressure with 4 credits
    $display("[TB] consumer backpressure");
    clearStats();
    for (int k = 0; k < 8; k++) pushExpect(12'h040 + 12'(k * 16));
    data_ready_i = 1'b0;
    d0 = done_cnt;
    applyStimulus(12'h040, 12'h010, 16'd8);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("backpressure requests issued", 64'(req_cnt), 64'd4);
    checkOutput("backpressure valid dropped", 64'(tcdm_req_q_valid_o), 64'd0);
    checkOutput("backpressure data valid", 64'(data_valid_o), 64'd1);
    checkOutput("backpressure busy", 64'(busy_o), 64'd1);
    data_ready_i = 1'b1;
    waitDone(d0, 60, "backpressure done timeout");
    checkOutput("backpressure total requests", 64'(req_cnt), 64'd8);
    checkDrained("backpressure");

    // Request stall on the second request
    $display("[TB] request stall");
    clearStats();
    pushExpect(12'h000);
    pushExpect(12'h008);
    pushExpect(12'h010);
    d0 = done_cnt;
    applyStimulus(12'h000, 12'h008, 16'd3);
    @(posedge clk); #1;
    tcdm_rsp_q_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tcdm_rsp_q_ready_i = 1'b1;
    waitDone(d0, 50, "stall done timeout");
    checkOutput("stall cycles observed", 64'(stall_obs), 64'd3);
`ifdef TCDM_STREAMER_STALL_CNT_EN
    checkOutput("stall counter", 64'(stall_cnt), 64'd3);
`endif
    checkDrained("stall");

    // Address wrap-around
    $display("[TB] wrap-around");
    clearStats();
    foreach (wrapAddrs[i]) pushExpect(wrapAddrs[i]);
    d0 = done_cnt;
    applyStimulus(12'hFF8, 12'h008, 16'd3);
    waitDone(d0, 50, "wrap done timeout");
    checkOutput("wrap requests", 64'(req_cnt), 64'd3);
    checkDrained("wrap");

    // Zero count
    $display("[TB] zero count");
    clearStats();
    d0 = done_cnt;
    applyStimulus(12'h100, 12'h008, 16'd0);
    checkOutput("zero done next cycle", 64'(done_o), 64'd1);
    checkOutput("zero busy", 64'(busy_o), 64'd0);
    checkOutput("zero req valid", 64'(tcdm_req_q_valid_o), 64'd0);
    @(posedge clk); #1;
    checkOutput("zero done single pulse", 64'(done_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero no requests", 64'(req_cnt), 64'd0);
    checkOutput("zero done count", 64'(done_cnt - d0), 64'd1);

    // Start while busy is ignored, then reset mid-RUN
    $display("[TB] start while busy, reset mid-run");
    clearStats();
    for (int k = 0; k < 8; k++) pushExpect(12'(k * 8));
    data_ready_i = 1'b0;
    applyStimulus(12'h000, 12'h008, 16'd8);
    @(posedge clk); #1;
    base_addr_i = 12'h800;
    stride_i = 12'h004;
    num_words_i = 16'd2;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("busy during run", 64'(busy_o), 64'd1);
    @(negedge clk); #1;
    rst_ni = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    #1;
    checkOutput("mid reset busy", 64'(busy_o), 64'd0);
    checkOutput("mid reset req valid", 64'(tcdm_req_q_valid_o), 64'd0);
    checkOutput("mid reset req addr", 64'(tcdm_req_addr_o), 64'd0);
    checkOutput("mid reset data valid", 64'(data_valid_o), 64'd0);
    checkOutput("mid reset data", data_o, 64'd0);
    checkOutput("mid reset done", 64'(done_o), 64'd0);
`ifdef TCDM_STREAMER_STALL_CNT_EN
    checkOutput("mid reset stall cnt", 64'(stall_cnt), 64'd0);
`endif
    data_ready_i = 1'b1;
    @(posedge clk); #2;
    rst_ni = 1'b1;
    checkOutput("stale response in flight", 64'(tcdm_rsp_p_valid_i), 64'd1);
    @(posedge clk); #1;
    checkOutput("stale response dropped", 64'(data_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle after reset", 64'(busy_o), 64'd0);

    clearStats();
    pushExpect(12'h010);
    pushExpect(12'h030);
    d0 = done_cnt;
    applyStimulus(12'h010, 12'h020, 16'd2);
    waitDone(d0, 50, "fresh start done timeout");
    checkOutput("fresh start requests", 64'(req_cnt), 64'd2);
    checkDrained("fresh start");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
